// File: rtl/sort_dma_pkg.sv
// rtl/sort_dma_pkg.sv - shared types and constants for the sort DMA master
package sort_dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        SORT_WAIT,
        WR_REQ,
        WR_RESP,
        FIN
    } state_t;

    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;
    localparam logic [3:0] WSTRB_FULL       = 4'hF;
    localparam int         WORD_BYTES       = 4;

    // Byte address of a word slot; wraps modulo 2**32 by construction.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] index);
        return base + index * 32'(WORD_BYTES);
    endfunction

endpackage

// File: rtl/sort_dma_if.sv
// rtl/sort_dma_if.sv - AXI4-lite initiator bus of the sort DMA master
interface sort_dma_if;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        output arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, arready, rvalid, rdata
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        input  arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, arready, rvalid, rdata
    );
endinterface

// File: rtl/sort_dma_wr_issue.sv
// rtl/sort_dma_wr_issue.sv - independent AW/W acceptance tracking for one write
module sort_dma_wr_issue (
    input  logic clk,
    input  logic rst,
    input  logic issue,
    input  logic awready,
    input  logic wready,
    output logic awvalid,
    output logic wvalid,
    output logic accepted
);
    logic aw_done;
    logic w_done;

    assign awvalid  = issue && !aw_done;
    assign wvalid   = issue && !w_done;
    // Each channel counts as taken if it was taken earlier or is being taken now.
    assign accepted = issue && (aw_done || awready) && (w_done || wready);

    always_ff @(posedge clk) begin
        if (rst || !issue || accepted) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (awready) aw_done <= 1'b1;
            if (wready)  w_done  <= 1'b1;
        end
    end
endmodule

// File: rtl/sort_dma_master.sv
// rtl/sort_dma_master.sv - gathers N words over AXI4-lite, sorts them externally, scatters the result
// Optional sorter-wait watchdog enabled by defining SORT_DMA_TIMEOUT_EN.
module sort_dma_master
    import sort_dma_pkg::*;
#(
    parameter int LOG_INPUT_NUM  = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [31:0]                       src_addr,
    input  logic [31:0]                       dst_addr,
    output logic                              busy,
    output logic                              done,
    output logic                              error,
    sort_dma_if.master                        mem_axi,
    output logic [32*(2**LOG_INPUT_NUM)-1:0]  x,
    output logic                              x_valid,
    input  logic [32*(2**LOG_INPUT_NUM)-1:0]  y,
    input  logic                              y_valid
);
    localparam int            N    = 2**LOG_INPUT_NUM;
    localparam int            IW   = (LOG_INPUT_NUM > 0) ? LOG_INPUT_NUM : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    state_t          state, state_nx;
    logic [31:0]     src_q, dst_q;
    logic [IW-1:0]   idx;
    logic [32*N-1:0] y_cap;
    logic            idx_last, y_take, tmo_hit, wr_accepted;

    assign idx_last = (idx == LAST);
    // The x_valid cycle is the first SORT_WAIT cycle, so y_valid there is stale by definition.
    assign y_take   = (state == SORT_WAIT) && !x_valid && y_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            idx     <= '0;
            x       <= '0;
            y_cap   <= '0;
            x_valid <= 1'b0;
        end else begin
            state   <= state_nx;
            x_valid <= (state == RD_DATA) && (state_nx == SORT_WAIT);
            case (state)
                IDLE: if (start) begin
                    src_q <= {src_addr[31:2], 2'b00};
                    dst_q <= {dst_addr[31:2], 2'b00};
                    idx   <= '0;
                end
                RD_DATA: if (mem_axi.rvalid) begin
                    x[32*idx +: 32] <= mem_axi.rdata;
                    if (!idx_last) idx <= idx + 1'b1;
                end
                SORT_WAIT: if (y_take) begin
                    y_cap <= y;
                    idx   <= '0;
                end
                WR_RESP: if (mem_axi.bvalid && !idx_last) idx <= idx + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (start) state_nx = RD_ADDR;
            RD_ADDR:   if (mem_axi.arready) state_nx = RD_DATA;
            RD_DATA:   if (mem_axi.rvalid) state_nx = idx_last ? SORT_WAIT : RD_ADDR;
            SORT_WAIT: begin
                if (tmo_hit)     state_nx = FIN;
                else if (y_take) state_nx = WR_REQ;
            end
            WR_REQ:    if (wr_accepted) state_nx = WR_RESP;
            WR_RESP:   if (mem_axi.bvalid) state_nx = idx_last ? FIN : WR_REQ;
            FIN:       state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

`ifdef SORT_DMA_TIMEOUT_EN
    logic [31:0] tmo_cnt;
    logic        err_q;

    // Counts cycles after the x_valid cycle; fires on the last allowed cycle without y_valid.
    assign tmo_hit = (state == SORT_WAIT) && !x_valid && !y_valid
                     && (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == IDLE && start) err_q <= 1'b0;
            if (tmo_hit) err_q <= 1'b1;
            if (state == SORT_WAIT && !x_valid) tmo_cnt <= tmo_cnt + 32'd1;
            else if (state != SORT_WAIT)        tmo_cnt <= '0;
        end
    end

    assign error = err_q;
`else
    assign tmo_hit = 1'b0;
    assign error   = 1'b0;
`endif

    sort_dma_wr_issue u_wr_issue (
        .clk      (clk),
        .rst      (rst),
        .issue    (state == WR_REQ),
        .awready  (mem_axi.awready),
        .wready   (mem_axi.wready),
        .awvalid  (mem_axi.awvalid),
        .wvalid   (mem_axi.wvalid),
        .accepted (wr_accepted)
    );

    assign mem_axi.arvalid = (state == RD_ADDR);
    assign mem_axi.araddr  = word_addr(src_q, 32'(idx));
    assign mem_axi.arprot  = AXI_PROT_DEFAULT;
    assign mem_axi.rready  = (state == RD_DATA);
    assign mem_axi.awaddr  = word_addr(dst_q, 32'(idx));
    assign mem_axi.awprot  = AXI_PROT_DEFAULT;
    assign mem_axi.wdata   = y_cap[32*idx +: 32];
    assign mem_axi.wstrb   = WSTRB_FULL;
    assign mem_axi.bready  = (state == WR_RESP);

    assign busy = (state != IDLE);
    assign done = (state == FIN);
endmodule

// File: tb/tb_sort_dma_master.sv
// tb/tb_sort_dma_master.sv - randomized self-checking bench for sort_dma_master
module tb_sort_dma_master;
    localparam int N   = 4;
    localparam int TMO = 16;

    logic            clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [31:0]     src_addr = '0, dst_addr = '0;
    logic            busy, done, error, x_valid;
    logic            y_valid = 1'b0;
    logic [32*N-1:0] x;
    logic [32*N-1:0] y = '0;

    sort_dma_if mem_axi();

    sort_dma_master #(.LOG_INPUT_NUM(2), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
        .busy(busy), .done(done), .error(error), .mem_axi(mem_axi),
        .x(x), .x_valid(x_valid), .y(y), .y_valid(y_valid)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [32*N-1:0] sort_words(input logic [32*N-1:0] v);
        logic [31:0]     w [N];
        logic [31:0]     t;
        logic [32*N-1:0] r;
        for (int i = 0; i < N; i++) w[i] = v[32*i +: 32];
        for (int i = 1; i < N; i++)
            for (int j = i; j > 0; j--)
                if (w[j-1] > w[j]) begin t = w[j]; w[j] = w[j-1]; w[j-1] = t; end
        for (int i = 0; i < N; i++) r[32*i +: 32] = w[i];
        return r;
    endfunction

    // Memory slave with per-channel ready/response delays
    logic [31:0] mem [logic [31:0]];
    logic [31:0] ar_q[$], aw_q[$], w_q[$];
    int  ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
    int  ar_wait, r_wait, aw_wait, w_wait, b_wait, b_cnt;
    bit  ar_hs, r_hs, aw_hs, w_hs, b_hs, rd_pend, aw_got, w_got;
    bit  p_arv, p_arr, p_awv, p_awr, p_wv, p_wr;
    logic [31:0] rd_addr, wr_addr, wr_data, p_araddr, p_awaddr, p_wdata;

    always @(negedge clk) begin
        if (rst) begin
            mem_axi.arready = 0; mem_axi.rvalid = 0; mem_axi.awready = 0;
            mem_axi.wready = 0; mem_axi.bvalid = 0;
            {ar_hs, r_hs, aw_hs, w_hs, b_hs, rd_pend, aw_got, w_got} = '0;
            {p_arv, p_arr, p_awv, p_awr, p_wv, p_wr} = '0;
            ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
        end else begin
            if (p_arv && !p_arr) begin
                chk("arvalid_hold", 32'(mem_axi.arvalid), 1);
                chk("araddr_hold", mem_axi.araddr, p_araddr);
            end
            if (p_awv && !p_awr) begin
                chk("awvalid_hold", 32'(mem_axi.awvalid), 1);
                chk("awaddr_hold", mem_axi.awaddr, p_awaddr);
            end
            if (p_wv && !p_wr) begin
                chk("wvalid_hold", 32'(mem_axi.wvalid), 1);
                chk("wdata_hold", mem_axi.wdata, p_wdata);
            end
            if (ar_hs) chk("arvalid_drop", 32'(mem_axi.arvalid), 0);
            if (aw_hs) chk("awvalid_drop", 32'(mem_axi.awvalid), 0);
            if (w_hs)  chk("wvalid_drop", 32'(mem_axi.wvalid), 0);
            if (ar_hs) begin mem_axi.arready = 0; rd_pend = 1; r_wait = 0; end
            if (r_hs)  mem_axi.rvalid = 0;
            if (aw_hs) begin mem_axi.awready = 0; aw_got = 1; end
            if (w_hs)  begin mem_axi.wready = 0; w_got = 1; end
            if (b_hs)  begin mem_axi.bvalid = 0; b_cnt++; end
            if (rd_pend) chk("one_read_outstanding", 32'(mem_axi.arvalid), 0);
            if (aw_got)  chk("one_aw_outstanding", 32'(mem_axi.awvalid), 0);
            if (w_got)   chk("one_w_outstanding", 32'(mem_axi.wvalid), 0);

            if (mem_axi.arvalid && !mem_axi.arready && !rd_pend) begin
                if (ar_wait >= ar_dly) begin mem_axi.arready = 1; ar_wait = 0; end else ar_wait++;
            end
            if (rd_pend) begin
                if (r_wait >= r_dly) begin
                    mem_axi.rvalid = 1;
                    mem_axi.rdata  = mem.exists(rd_addr) ? mem[rd_addr] : 32'hDEAD_BEEF;
                    rd_pend = 0;
                end else r_wait++;
            end
            if (mem_axi.awvalid && !mem_axi.awready && !aw_got) begin
                if (aw_wait >= aw_dly) begin mem_axi.awready = 1; aw_wait = 0; end else aw_wait++;
            end
            if (mem_axi.wvalid && !mem_axi.wready && !w_got) begin
                if (w_wait >= w_dly) begin mem_axi.wready = 1; w_wait = 0; end else w_wait++;
            end
            if (aw_got && w_got) begin
                if (b_wait >= b_dly) begin
                    mem[wr_addr] = wr_data; mem_axi.bvalid = 1;
                    aw_got = 0; w_got = 0; b_wait = 0;
                end else b_wait++;
            end

            ar_hs = mem_axi.arvalid && mem_axi.arready;
            r_hs  = mem_axi.rvalid && mem_axi.rready;
            aw_hs = mem_axi.awvalid && mem_axi.awready;
            w_hs  = mem_axi.wvalid && mem_axi.wready;
            b_hs  = mem_axi.bvalid && mem_axi.bready;
            if (ar_hs) begin
                rd_addr = mem_axi.araddr; ar_q.push_back(mem_axi.araddr);
                chk("arprot", 32'(mem_axi.arprot), 0);
            end
            if (aw_hs) begin
                wr_addr = mem_axi.awaddr; aw_q.push_back(mem_axi.awaddr);
                chk("awprot", 32'(mem_axi.awprot), 0);
            end
            if (w_hs) begin
                wr_data = mem_axi.wdata; w_q.push_back(mem_axi.wdata);
                chk("wstrb", 32'(mem_axi.wstrb), 32'hF);
            end
            p_arv = mem_axi.arvalid; p_arr = mem_axi.arready; p_araddr = mem_axi.araddr;
            p_awv = mem_axi.awvalid; p_awr = mem_axi.awready; p_awaddr = mem_axi.awaddr;
            p_wv  = mem_axi.wvalid;  p_wr  = mem_axi.wready;  p_wdata  = mem_axi.wdata;
        end
    end

    // Ascending sorter; optionally drives a bogus y_valid on the x_valid cycle
    bit  sorter_en = 1, junk_en = 0, s_pend;
    int  sort_dly = 0, s_wait, xv_cnt, done_cnt, xv_cyc, done_cyc;
    logic done_err;
    logic [32*N-1:0] y_ref;

    always @(negedge clk) begin
        if (rst) begin
            y_valid = 0; s_pend = 0;
        end else begin
            if (x_valid) begin
                xv_cnt++; xv_cyc = cyc;
                y_ref = sort_words(x);
                s_pend = sorter_en; s_wait = 0;
                y_valid = junk_en; y = ~y_ref;
            end else if (s_pend) begin
                y_valid = 0;
                if (s_wait >= sort_dly) begin y = y_ref; y_valid = 1; s_pend = 0; end else s_wait++;
            end
            if (done) begin done_cnt++; done_cyc = cyc; done_err = error; y_valid = 0; end
        end
    end

    task automatic clear_mon();
        ar_q.delete(); aw_q.delete(); w_q.delete();
        b_cnt = 0; xv_cnt = 0; done_cnt = 0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin @(posedge clk); #1; k++; end
        chk({tag, " done_within_budget"}, 32'(done_cnt != 0), 1);
    endtask

    task automatic run_job(input string tag, input logic [31:0] s, input logic [31:0] d,
                           input logic [32*N-1:0] pk, input bit extra_start);
        logic [31:0]     sb, db;
        logic [32*N-1:0] srt;
        sb = {s[31:2], 2'b00};
        db = {d[31:2], 2'b00};
        for (int i = 0; i < N; i++) mem[sb + 32'(4*i)] = pk[32*i +: 32];
        srt = sort_words(pk);
        clear_mon();
        @(posedge clk); #1; start = 1; src_addr = s; dst_addr = d;
        @(posedge clk); #1; start = 0; src_addr = $urandom; dst_addr = $urandom;
        chk({tag, " busy_after_start"}, 32'(busy), 1);
        if (extra_start) begin
            @(posedge clk); #1; start = 1; src_addr = 32'h4000; dst_addr = 32'h5000;
            @(posedge clk); #1; start = 0;
        end
        wait_done(tag, 3000);
        repeat (2) @(posedge clk); #1;
        chk({tag, " busy_idle"}, 32'(busy), 0);
        chk({tag, " read_count"}, 32'(ar_q.size()), N);
        chk({tag, " write_count"}, 32'(aw_q.size()), N);
        chk({tag, " b_beats"}, 32'(b_cnt), N);
        chk({tag, " x_valid_pulses"}, 32'(xv_cnt), 1);
        chk({tag, " done_pulses"}, 32'(done_cnt), 1);
        chk({tag, " error_at_done"}, 32'(done_err), 0);
        if (ar_q.size() == N && aw_q.size() == N && w_q.size() == N)
            for (int i = 0; i < N; i++) begin
                chk({tag, $sformatf(" araddr%0d", i)}, ar_q[i], sb + 32'(4*i));
                chk({tag, $sformatf(" awaddr%0d", i)}, aw_q[i], db + 32'(4*i));
                chk({tag, $sformatf(" wdata%0d", i)}, w_q[i], srt[32*i +: 32]);
            end
    endtask

    initial begin
        logic [32*N-1:0] pk;
        int k;
        mem_axi.arready = 0; mem_axi.rvalid = 0; mem_axi.rdata = '0;
        mem_axi.awready = 0; mem_axi.wready = 0; mem_axi.bvalid = 0;
        repeat (3) @(posedge clk); #1;
        chk("reset busy", 32'(busy), 0);
        chk("reset done", 32'(done), 0);
        chk("reset error", 32'(error), 0);
        chk("reset x_valid", 32'(x_valid), 0);
        chk("reset arvalid", 32'(mem_axi.arvalid), 0);
        chk("reset awvalid", 32'(mem_axi.awvalid), 0);
        chk("reset wvalid", 32'(mem_axi.wvalid), 0);
        chk("reset rready", 32'(mem_axi.rready), 0);
        chk("reset bready", 32'(mem_axi.bready), 0);
        for (int i = 0; i < N; i++) chk($sformatf("reset x%0d", i), x[32*i +: 32], 0);
        rst = 0;

        pk = {32'd1, 32'd7, 32'd3, 32'd9};
        run_job("basic", 32'h100, 32'h200, pk, 0);
        for (int i = 0; i < N; i++)
            chk($sformatf("basic mem_dst%0d", i), mem[32'h200 + 32'(4*i)], pk[32*0 +: 32] == 9 ?
                (i == 0 ? 32'd1 : i == 1 ? 32'd3 : i == 2 ? 32'd7 : 32'd9) : 32'hX);

        aw_dly = 3; w_dly = 0;
        run_job("aw_late", 32'h140, 32'h240, {$urandom, $urandom, $urandom, $urandom}, 0);
        aw_dly = 0; w_dly = 3;
        run_job("w_late", 32'h180, 32'h280, {$urandom, $urandom, $urandom, $urandom}, 0);
        w_dly = 0;

        run_job("busy_start", 32'h103, 32'h2C1, {$urandom, $urandom, $urandom, $urandom}, 1);
        run_job("wrap", 32'hFFFF_FFF8, 32'hFFFF_FFFC, {$urandom, $urandom, $urandom, $urandom}, 0);

        clear_mon(); r_dly = 2;
        @(posedge clk); #1; start = 1; src_addr = 32'h300; dst_addr = 32'h380;
        @(posedge clk); #1; start = 0;
        k = 0;
        while (ar_q.size() < 2 && k < 200) begin @(posedge clk); #1; k++; end
        chk("rst_mid reached_2nd_read", 32'(ar_q.size() >= 2), 1);
        rst = 1;
        @(posedge clk); #1;
        chk("rst_mid arvalid", 32'(mem_axi.arvalid), 0);
        chk("rst_mid rready", 32'(mem_axi.rready), 0);
        chk("rst_mid awvalid", 32'(mem_axi.awvalid), 0);
        chk("rst_mid wvalid", 32'(mem_axi.wvalid), 0);
        chk("rst_mid busy", 32'(busy), 0);
        chk("rst_mid x0", x[31:0], 0);
        rst = 0;
        repeat (3) @(posedge clk); #1;
        chk("rst_mid no_more_reads", 32'(ar_q.size()), 2);
        chk("rst_mid still_idle", 32'(busy), 0);
        r_dly = 0;
        run_job("after_rst", 32'h300, 32'h380, {$urandom, $urandom, $urandom, $urandom}, 0);

        for (int t = 0; t < 6; t++) begin
            ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
            b_dly = $urandom_range(0, 3); sort_dly = $urandom_range(0, 5);
            junk_en = 1'($urandom_range(0, 1));
            run_job($sformatf("rand%0d", t), $urandom, $urandom,
                    {$urandom, $urandom, $urandom, $urandom}, 0);
        end
        ar_dly = 0; r_dly = 0; aw_dly = 0; w_dly = 0; b_dly = 0; junk_en = 0;

`ifdef SORT_DMA_TIMEOUT_EN
        sorter_en = 0; clear_mon();
        @(posedge clk); #1; start = 1; src_addr = 32'h500; dst_addr = 32'h600;
        @(posedge clk); #1; start = 0;
        wait_done("timeout", 500);
        repeat (2) @(posedge clk); #1;
        chk("timeout reads", 32'(ar_q.size()), N);
        chk("timeout no_aw", 32'(aw_q.size()), 0);
        chk("timeout error_with_done", 32'(done_err), 1);
        chk("timeout latency", 32'(done_cyc - xv_cyc), TMO + 1);
        chk("timeout error_held", 32'(error), 1);
        sorter_en = 1;
        run_job("post_timeout", 32'h500, 32'h600, {$urandom, $urandom, $urandom, $urandom}, 0);
`else
        sort_dly = 40; junk_en = 1;
        run_job("slow_sorter", 32'h500, 32'h600, {$urandom, $urandom, $urandom, $urandom}, 0);
        chk("slow_sorter error", 32'(error), 0);
        sort_dly = 0; junk_en = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
